// File: rtl/lector_teclado_if.sv
// lector_teclado_if: keypad row/column lines plus the decoded key outputs.
interface lector_teclado_if;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] tecla;
    logic       tecla_valida;
    modport master (input filas, output columnas, tecla, tecla_valida);
    modport slave (output filas, input columnas, tecla, tecla_valida);
endinterface

// File: rtl/lector_teclado.sv
// lector_teclado: 4x4 keypad column scanner with press/release debounce and
// a single-cycle pulse per accepted key.
module lector_teclado #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 200000
) (
    input logic              clk,
    input logic              rst,
    lector_teclado_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);
    // Nibble table indexed by {row, column}
    localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, filas_s;
    logic [1:0]    col_q, col_d, row_q, row_d, row_sel;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    tecla_q, tecla_d;
    logic          valida_q, valida_d, div_wrap, one_low, row_low;

    assign div_wrap = div_q == DIV_LAST;
    assign one_low  = filas_s inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    assign row_sel  = !filas_s[0] ? 2'd0 : !filas_s[1] ? 2'd1 : !filas_s[2] ? 2'd2 : 2'd3;
    assign row_low  = !filas_s[row_q];
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        tecla_d  = tecla_q;
        valida_d = 1'b0;
        case (state_q)
            SCAN: begin
                div_d = div_wrap ? '0 : div_q + 1'b1;
                if (div_wrap && one_low) begin
                    row_d   = row_sel;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end else if (div_wrap) begin
                    col_d = col_q + 2'd1;
                end
            end
            DEBOUNCE: begin
                if (cnt_q == CNT_MAX) begin
                    tecla_d  = KEY_MAP[{row_q, col_q}];
                    valida_d = 1'b1;
                    state_d  = HOLD;
                end else if (row_low) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d = SCAN;
                end
            end
            HOLD: begin
                cnt_d   = row_low ? cnt_q : '0;
                state_d = row_low ? HOLD : RELEASE;
            end
            RELEASE: begin
                cnt_d   = row_low ? '0 : cnt_inc;
                // Back to a fresh scan from column 0 once the release is stable
                if (cnt_q == CNT_MAX) begin
                    state_d = SCAN;
                    col_d   = '0;
                    div_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 4'hF;
            filas_s  <= 4'hF;
            state_q  <= SCAN;
            col_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            tecla_q  <= 4'h0;
            valida_q <= 1'b0;
        end else begin
            sync1_q  <= kp.filas;
            filas_s  <= sync1_q;
            state_q  <= state_d;
            col_q    <= col_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            tecla_q  <= tecla_d;
            valida_q <= valida_d;
        end
    end

    assign kp.columnas     = ~(4'b0001 << col_q);
    assign kp.tecla        = tecla_q;
    assign kp.tecla_valida = valida_q & ~rst;
endmodule
